// File: rtl/fetch_if.sv
// fetch_if: fetch-stage control inputs, imem port and IF/ID outputs.
interface fetch_if #(
  parameter int NB_PC    = 32,
  parameter int NB_INSTR = 32,
  parameter int NB_COUNT = 32
);
  logic                i_enable;
  logic                i_stall;
  logic                i_branch_taken;
  logic [NB_PC-1:0]    i_branch_addr;
  logic [NB_PC-1:0]    o_imem_addr;
  logic [NB_INSTR-1:0] i_imem_data;
  logic [NB_INSTR-1:0] o_instr;
  logic [NB_PC-1:0]    o_pc_next;
  logic                o_valid;
  logic                o_halted;
  logic [NB_COUNT-1:0] o_fetch_count;
  modport master (
    input  i_enable, i_stall, i_branch_taken, i_branch_addr, i_imem_data,
    output o_imem_addr, o_instr, o_pc_next, o_valid, o_halted, o_fetch_count
  );
  modport slave (
    output i_enable, i_stall, i_branch_taken, i_branch_addr, i_imem_data,
    input  o_imem_addr, o_instr, o_pc_next, o_valid, o_halted, o_fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, IF/ID register, HALT detection and fetched-instruction counter.
module fetch_stage #(
  parameter int                   NB_PC       = 32,
  parameter int                   NB_INSTR    = 32,
  parameter int                   NB_OPCODE   = 6,
  parameter int                   NB_COUNT    = 32,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = '1,
  parameter logic [NB_INSTR-1:0]  NOP_INSTR   = '0
) (
  input logic     i_clock,
  input logic     i_reset,
  fetch_if.master bus
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t              state, state_d;
  logic [NB_PC-1:0]    pc, pc_d, pc_next, pc_next_d, pc_inc;
  logic [NB_INSTR-1:0] instr, instr_d;
  logic                valid, valid_d;
  logic [NB_COUNT-1:0] count, count_d;
  logic                go, is_halt;
  assign pc_inc  = pc + NB_PC'(4);
  assign go      = bus.i_enable && !bus.i_stall;
  assign is_halt = bus.i_imem_data[NB_INSTR-1 -: NB_OPCODE] == HALT_OPCODE;
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pc_next_d = pc_next;
    instr_d   = instr;
    valid_d   = valid;
    count_d   = count;
    if (go && state == HALTED) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (go && bus.i_branch_taken) begin
      pc_d    = {bus.i_branch_addr[NB_PC-1:2], 2'b00};
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (go) begin
      pc_d      = pc_inc;
      pc_next_d = pc_inc;
      instr_d   = bus.i_imem_data;
      valid_d   = 1'b1;
      count_d   = count + NB_COUNT'(1);
      state_d   = is_halt ? HALTED : RUN;
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= RUN;
      pc      <= '0;
      pc_next <= '0;
      instr   <= NOP_INSTR;
      valid   <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      pc_next <= pc_next_d;
      instr   <= instr_d;
      valid   <= valid_d;
      count   <= count_d;
    end
  end
  assign bus.o_imem_addr   = pc;
  assign bus.o_instr       = instr;
  assign bus.o_pc_next     = pc_next;
  assign bus.o_valid       = valid;
  assign bus.o_halted      = state == HALTED;
  assign bus.o_fetch_count = count;
endmodule
